// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB encodings, slave state type and burst length helper
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Zero means undefined length (HBURST=INCR): no beat limit.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    case (hburst)
      HBURST_SINGLE:                return 5'd1;
      HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
      HBURST_WRAP16, HBURST_INCR16: return 5'd16;
      default:                      return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_addr_calc.sv
// rtl/ahb_burst_addr_calc.sv - next expected beat address for INCR and WRAP bursts
module ahb_burst_addr_calc
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [2:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] sum;
  logic [ADDR_W-1:0] span_mask;

  // Bits inside span_mask wrap; bits outside are held. All-ones means plain increment.
  always_comb begin
    incr = ADDR_W'(1) << size;
    sum  = addr + incr;
    case (burst)
      HBURST_WRAP4:  span_mask = (incr << 2) - ADDR_W'(1);
      HBURST_WRAP8:  span_mask = (incr << 3) - ADDR_W'(1);
      HBURST_WRAP16: span_mask = (incr << 4) - ADDR_W'(1);
      default:       span_mask = '1;
    endcase
    next_addr = (addr & ~span_mask) | (sum & span_mask);
  end

endmodule

// File: rtl/ahb_mem_slave_p.sv
// rtl/ahb_mem_slave_p.sv - AHB memory slave with burst sequencing and two-cycle ERROR
// Optional wait states per data phase when AHB_MEM_WAIT_EN is defined.
module ahb_mem_slave_p
  import ahb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELx,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int NB    = DATA_W / 8;
  localparam int LB    = $clog2(NB);
  localparam int DEPTH = MEM_BYTES / NB;
  localparam int IW    = $clog2(DEPTH);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be 0..15");
  end
  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
    $error("DATA_W must be 32 or 64");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ap_addr_q, ap_addr_d, exp_addr_q, exp_addr_d, nxt_addr;
  logic              ap_write_q, ap_write_d, trk_q, trk_d;
  logic [NB-1:0]     ap_mask_q, ap_mask_d, lane_mask;
  logic [2:0]        burst_q, burst_d;
  logic [4:0]        beat_cnt_q, beat_cnt_d, blen;
  logic [DATA_W-1:0] hrdata_q, hrdata_d, rd_word;
  logic [7:0]        mem_q [NB][DEPTH];
  logic              acc, acc_err, seq_err, rd_write, fwd, wr_en;
  logic [IW-1:0]     rd_idx, ap_idx;
  logic [7:0]        nbytes;
  state_t            dphase_st;

  ahb_burst_addr_calc #(.ADDR_W(ADDR_W)) u_calc (
    .addr      (HADDR),
    .size      (HSIZE),
    .burst     (HBURST),
    .next_addr (nxt_addr)
  );

  assign acc    = HSELx & HREADY & HTRANS[1] & HREADYOUT;
  assign blen   = burst_len(burst_q);
  assign ap_idx = ap_addr_q[LB +: IW];
  assign wr_en  = (state_q == ST_DATA) && ap_write_q;

  // A SEQ is only legal while tracking survives, on the expected address, within the burst length.
  assign seq_err = (HTRANS == HTRANS_SEQ) &&
                   (!trk_q || (HADDR != exp_addr_q) || ((blen != 5'd0) && (beat_cnt_q >= blen)));
  assign acc_err = (HADDR >= ADDR_W'(MEM_BYTES)) || (HSIZE > 3'(LB)) ||
                   ((HADDR & ~({ADDR_W{1'b1}} << HSIZE)) != '0) || seq_err;

`ifdef AHB_MEM_WAIT_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;
  assign dphase_st = (WAIT_CYCLES != 0) ? ST_WAIT : ST_DATA;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (acc) wait_cnt_d = 4'(WAIT_CYCLES - 1);
    else if (state_q == ST_WAIT && wait_cnt_q != 4'd0) wait_cnt_d = wait_cnt_q - 4'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) wait_cnt_q <= 4'd0;
    else          wait_cnt_q <= wait_cnt_d;
  end
`else
  assign dphase_st = ST_DATA;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: if (acc) state_d = acc_err ? ST_ERR1 : dphase_st;
`ifdef AHB_MEM_WAIT_EN
      ST_WAIT: state_d = (wait_cnt_q == 4'd0) ? ST_DATA : ST_WAIT;
`endif
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    HRDATA    = hrdata_q;
  end

  always_comb begin
    nbytes = 8'(1) << HSIZE;
    for (int l = 0; l < NB; l++) begin
      lane_mask[l] = (l >= int'(HADDR[LB-1:0])) && (l < int'(HADDR[LB-1:0]) + int'(nbytes));
    end
  end

  // Address-phase capture and burst tracking; an errored beat ends tracking.
  always_comb begin
    ap_addr_d  = ap_addr_q;
    ap_write_d = ap_write_q;
    ap_mask_d  = ap_mask_q;
    exp_addr_d = exp_addr_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    trk_d      = trk_q;
    if (acc) begin
      ap_addr_d  = HADDR;
      ap_write_d = HWRITE;
      ap_mask_d  = lane_mask;
      if (acc_err) begin
        trk_d = 1'b0;
      end else begin
        exp_addr_d = nxt_addr;
        if (HTRANS == HTRANS_NONSEQ) begin
          trk_d      = 1'b1;
          burst_d    = HBURST;
          beat_cnt_d = 5'd1;
        end else begin
          beat_cnt_d = beat_cnt_q + 5'(beat_cnt_q != 5'h1f);
        end
      end
    end
  end

  // The read sampled on entry to ST_DATA forwards lanes of a write committing at the same edge.
  always_comb begin
    rd_idx   = (state_q == ST_WAIT) ? ap_idx : HADDR[LB +: IW];
    rd_write = (state_q == ST_WAIT) ? ap_write_q : HWRITE;
    fwd      = wr_en && (ap_idx == rd_idx);
    for (int l = 0; l < NB; l++) begin
      rd_word[8*l +: 8] = (fwd && ap_mask_q[l]) ? HWDATA[8*l +: 8] : mem_q[l][rd_idx];
    end
    hrdata_d = hrdata_q;
    if (state_d == ST_DATA && !rd_write) hrdata_d = rd_word;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_addr_q  <= '0;
      ap_write_q <= 1'b0;
      ap_mask_q  <= '0;
      exp_addr_q <= '0;
      burst_q    <= HBURST_SINGLE;
      beat_cnt_q <= 5'd0;
      trk_q      <= 1'b0;
      hrdata_q   <= '0;
    end else begin
      ap_addr_q  <= ap_addr_d;
      ap_write_q <= ap_write_d;
      ap_mask_q  <= ap_mask_d;
      exp_addr_q <= exp_addr_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      trk_q      <= trk_d;
      hrdata_q   <= hrdata_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int l = 0; l < NB; l++) begin
        if (ap_mask_q[l]) mem_q[l][ap_idx] <= HWDATA[8*l +: 8];
      end
    end
  end

endmodule
